bus_arbiter: RTL



---
 rtl/bus_arbiter_if.sv | 49 ++++
 rtl/bus_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_if
// Purpose  : Request/grant/done bundle for the masters plus the downstream
//            single-port bus command/response signals of bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64
);
    localparam int C_OWNER_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS*3-1:0]      m_rd_ctrl;
    logic [NUM_MASTERS*3-1:0]      m_wr_ctrl;
    logic [NUM_MASTERS-1:0]        m_lock;
    logic [NUM_MASTERS-1:0]        m_gnt;
    logic [NUM_MASTERS-1:0]        m_done;
    logic [NUM_MASTERS-1:0]        m_err;
    logic [DATA_W-1:0]             m_rdata;
    logic [2:0]                    bus_rd_ctrl;
    logic [2:0]                    bus_wr_ctrl;
    logic [ADDR_W-1:0]             bus_addr;
    logic [DATA_W-1:0]             bus_din;
    logic [DATA_W-1:0]             bus_dout;
    logic                          bus_ready;
    logic                          bus_busy;
    logic [C_OWNER_W-1:0]          owner;

    // master: the arbiter itself; slave: the requesting masters and bus slave
    modport master (
        input  m_req, m_addr, m_wdata, m_rd_ctrl, m_wr_ctrl, m_lock,
        input  bus_dout, bus_ready,
        output m_gnt, m_done, m_err, m_rdata,
        output bus_rd_ctrl, bus_wr_ctrl, bus_addr, bus_din, bus_busy, owner
    );

    modport slave (
        output m_req, m_addr, m_wdata, m_rd_ctrl, m_wr_ctrl, m_lock,
        output bus_dout, bus_ready,
        input  m_gnt, m_done, m_err, m_rdata,
        input  bus_rd_ctrl, bus_wr_ctrl, bus_addr, bus_din, bus_busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : N-master arbiter (fixed priority or round-robin) for the single
//            port system bus, with wait states, lock and access timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int RR_MODE     = 0,
    parameter int TIMEOUT     = 16
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);
    localparam int C_OWNER_W = $clog2(NUM_MASTERS);
    localparam int C_CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic [C_OWNER_W-1:0]   r_owner;
    logic [C_OWNER_W-1:0]   r_ptr;
    logic [C_CNT_W-1:0]     r_cnt;
    logic [2:0]             r_rd_ctrl;
    logic [2:0]             r_wr_ctrl;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_din;
    logic                   r_busy;

    logic                   w_in_access;
    logic                   w_timeout;
    logic                   w_complete;
    logic                   w_arb_en;
    logic                   w_lock_hold;
    logic [NUM_MASTERS-1:0] w_owner_oh;
    logic [NUM_MASTERS-1:0] w_cand;
    logic                   w_found_lo;
    logic                   w_found_hi;
    logic                   w_found;
    logic [C_OWNER_W-1:0]   w_win_lo;
    logic [C_OWNER_W-1:0]   w_win_hi;
    logic [C_OWNER_W-1:0]   w_win;

    assign w_in_access = (r_state == ST_ACCESS);
    assign w_owner_oh  = NUM_MASTERS'(1) << r_owner;
    assign w_timeout   = (TIMEOUT != 0) && w_in_access && !bus.bus_ready && (r_cnt == C_CNT_LAST);
    assign w_complete  = w_in_access && (bus.bus_ready || w_timeout);
    assign w_arb_en    = !w_in_access || w_complete;
    assign w_lock_hold = w_in_access && bus.m_lock[r_owner] && bus.m_req[r_owner];

    // Descending scan: lowest candidate overall, and lowest candidate above the RR pointer
    always_comb begin
        w_cand = bus.m_req;
        if (w_in_access && !bus.m_lock[r_owner])
            w_cand = bus.m_req & ~w_owner_oh;
        w_found_lo = 1'b0;
        w_found_hi = 1'b0;
        w_win_lo   = '0;
        w_win_hi   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_found_lo = 1'b1;
                w_win_lo   = C_OWNER_W'(i);
                if (C_OWNER_W'(i) > r_ptr) begin
                    w_found_hi = 1'b1;
                    w_win_hi   = C_OWNER_W'(i);
                end
            end
        end
        w_found = w_lock_hold || w_found_lo;
        if (w_lock_hold)
            w_win = r_owner;
        else if ((RR_MODE != 0) && w_found_hi)
            w_win = w_win_hi;
        else
            w_win = w_win_lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_ptr     <= C_OWNER_W'(NUM_MASTERS - 1);
            r_cnt     <= '0;
            r_rd_ctrl <= '0;
            r_wr_ctrl <= '0;
            r_addr    <= '0;
            r_din     <= '0;
            r_busy    <= 1'b0;
        end else if (w_arb_en && w_found) begin
            r_state   <= ST_ACCESS;
            r_busy    <= 1'b1;
            r_gnt     <= NUM_MASTERS'(1) << w_win;
            r_owner   <= w_win;
            r_ptr     <= w_win;
            r_cnt     <= '0;
            r_addr    <= bus.m_addr[int'(w_win)*ADDR_W +: ADDR_W];
            r_din     <= bus.m_wdata[int'(w_win)*DATA_W +: DATA_W];
            r_rd_ctrl <= bus.m_rd_ctrl[int'(w_win)*3 +: 3];
            r_wr_ctrl <= bus.m_wr_ctrl[int'(w_win)*3 +: 3];
        end else if (w_complete) begin
            // address and write data deliberately hold their last values
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_rd_ctrl <= '0;
            r_wr_ctrl <= '0;
        end else if (w_in_access && (TIMEOUT != 0)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.m_gnt       = r_gnt;
    assign bus.owner       = r_owner;
    assign bus.bus_busy    = r_busy;
    assign bus.bus_rd_ctrl = r_rd_ctrl;
    assign bus.bus_wr_ctrl = r_wr_ctrl;
    assign bus.bus_addr    = r_addr;
    assign bus.bus_din     = r_din;
    assign bus.m_done      = w_complete ? w_owner_oh : '0;
    assign bus.m_err       = w_timeout ? w_owner_oh : '0;
    assign bus.m_rdata     = bus.bus_dout;
endmodule
`default_nettype wire
